// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file: default
// geometry, address/data types and the priority-resolved write-port matcher.
package regfile_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

    // Upper bounds used to give wr_hit() fixed-width arguments; callers
    // zero-pad unused write ports and address bits.
    localparam int MAX_WRITE = 8;
    localparam int MAX_AW    = 8;
    localparam int WP_W      = $clog2(MAX_WRITE);

    typedef logic [$clog2(DEFAULT_NREGS)-1:0] reg_addr_t;
    typedef logic [DEFAULT_XLEN-1:0]          reg_data_t;

    typedef struct packed {
        logic            hit;
        logic [WP_W-1:0] port;
    } wr_hit_t;

    // Finds the write port targeting addr; when several match, the highest
    // port index wins because later iterations overwrite earlier ones.
    function automatic wr_hit_t wr_hit(
        input logic [MAX_WRITE-1:0]        en,
        input logic [MAX_WRITE*MAX_AW-1:0] addrs,
        input logic [MAX_AW-1:0]           addr
    );
        wr_hit_t res;
        res.hit  = 1'b0;
        res.port = {WP_W{1'b0}};
        for (int j = 0; j < MAX_WRITE; j++) begin
            if (en[j] && (addrs[j*MAX_AW +: MAX_AW] == addr)) begin
                res.hit  = 1'b1;
                res.port = WP_W'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one flag per architectural register, set by allocation at
// decode and cleared by writeback; allocation wins over a same-cycle clear.
module regfile_scoreboard #(
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_en,
    input  logic [AW-1:0]      alloc_addr,
    input  logic [NREGS-1:0]   wr_clr,
    input  logic [NREAD*AW-1:0] rd_addr,
    input  logic [NREAD-1:0]   rd_wr_hit,
    output logic [NREAD-1:0]   rd_busy
);

    localparam bit            ZR      = (ZERO_REG != 0);
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);

    logic [NREGS-1:0] busy_r;

    // Busy flags: alloc sets (newer producer), matching write clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (alloc_en && (alloc_addr == AW'(r)) && !(ZR && (r == 0))) begin
                    busy_r[r] <= 1'b1;
                end else if (wr_clr[r]) begin
                    busy_r[r] <= 1'b0;
                end else begin
                    busy_r[r] <= busy_r[r];
                end
            end
        end
    end

    // Per-port busy view; a same-cycle write hides busy unless it is re-allocated.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (({1'b0, rd_addr[i*AW +: AW]} < NREGS_W) &&
                !(ZR && (rd_addr[i*AW +: AW] == {AW{1'b0}}))) begin
                rd_busy[i] = busy_r[rd_addr[i*AW +: AW]] &&
                             (!rd_wr_hit[i] ||
                              (alloc_en && (alloc_addr == rd_addr[i*AW +: AW])));
            end else begin
                rd_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write-to-read bypass and
// a busy scoreboard for RAW hazard detection at decode.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr
);

    localparam bit          ZR      = (ZERO_REG != 0);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0]             regs_r      [NREGS];
    logic [MAX_WRITE-1:0]        wr_en_pad_s;
    logic [MAX_WRITE*MAX_AW-1:0] wr_addr_pad_s;
    wr_hit_t                     reg_hit_s   [NREGS];
    logic [XLEN-1:0]             reg_wdata_s [NREGS];
    logic [NREGS-1:0]            wr_clr_s;
    wr_hit_t                     rd_hit_s    [NREAD];
    logic [NREAD-1:0]            rd_wr_hit_s;
    logic [NREAD-1:0]            rd_ok_s;

    // Picks the data of the given write port.
    function automatic logic [XLEN-1:0] sel_wdata(
        input logic [WP_W-1:0]        p,
        input logic [NWRITE*XLEN-1:0] d
    );
        logic [XLEN-1:0] v;
        v = {XLEN{1'b0}};
        for (int j = 0; j < NWRITE; j++) begin
            v = (p == WP_W'(j)) ? d[j*XLEN +: XLEN] : v;
        end
        return v;
    endfunction

    // Widen write ports to the fixed shape expected by wr_hit().
    always_comb begin
        wr_en_pad_s   = '0;
        wr_addr_pad_s = '0;
        for (int j = 0; j < NWRITE; j++) begin
            wr_en_pad_s[j]                   = wr_en[j];
            wr_addr_pad_s[j*MAX_AW +: MAX_AW] = MAX_AW'(wr_addr[j*AW +: AW]);
        end
    end

    // Resolve the winning write port and its data for every register.
    always_comb begin
        wr_clr_s = '0;
        for (int r = 0; r < NREGS; r++) begin
            reg_hit_s[r]   = wr_hit(wr_en_pad_s, wr_addr_pad_s, MAX_AW'(r));
            reg_wdata_s[r] = sel_wdata(reg_hit_s[r].port, wr_data);
            wr_clr_s[r]    = reg_hit_s[r].hit;
        end
    end

    // Register storage; reg 0 stays zero when hardwired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (reg_hit_s[r].hit && !(ZR && (r == 0))) begin
                    regs_r[r] <= reg_wdata_s[r];
                end else begin
                    regs_r[r] <= regs_r[r];
                end
            end
        end
    end

    // Combinational read with bypass; held at zero while reset is asserted.
    always_comb begin
        rd_data     = '0;
        rd_wr_hit_s = '0;
        rd_ok_s     = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_hit_s[i]    = wr_hit(wr_en_pad_s, wr_addr_pad_s, MAX_AW'(rd_addr[i*AW +: AW]));
            rd_wr_hit_s[i] = rd_hit_s[i].hit;
            rd_ok_s[i]     = ({1'b0, rd_addr[i*AW +: AW]} < NREGS_W) &&
                             !(ZR && (rd_addr[i*AW +: AW] == {AW{1'b0}}));
            if (!rst_n || !rd_ok_s[i]) begin
                rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (rd_hit_s[i].hit) begin
                rd_data[i*XLEN +: XLEN] = sel_wdata(rd_hit_s[i].port, wr_data);
            end else begin
                rd_data[i*XLEN +: XLEN] = regs_r[rd_addr[i*AW +: AW]];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_clr     (wr_clr_s),
        .rd_addr    (rd_addr),
        .rd_wr_hit  (rd_wr_hit_s),
        .rd_busy    (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read, 2 write ports). Stimulus pushes the
// expected outputs for the current cycle into a queue; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;

    regfile_mp #(
        .XLEN     (32),
        .NREGS    (32),
        .NREAD    (2),
        .NWRITE   (2),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr)
    );

    typedef struct {
        int          cyc;
        string       name;
        bit          is_busy;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_miss  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]          = en;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr[4:0] = a0;
        rd_addr[9:5] = a1;
    endtask

    task automatic idle();
        wr_en    = 2'b00;
        alloc_en = 1'b0;
    endtask

    task automatic exp_rd(input string nm, input int p, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.is_busy = 1'b0; e.port = p; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_busy(input string nm, input int p, input logic b);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.is_busy = 1'b1; e.port = p; e.val = {31'd0, b};
        exp_q.push_back(e);
    endtask

    // Monitor: compare every expectation due this cycle on the falling edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_vec = n_vec + 1;
                if (e.is_busy) act = {31'd0, rd_busy[e.port]};
                else           act = rd_data[e.port*32 +: 32];
                if (e.cyc != cyc) begin
                    n_miss = n_miss + 1;
                    $display("FAIL %s port%0d: not sampled in its cycle (%0d vs %0d)", e.name, e.port, cyc, e.cyc);
                end else if (act !== e.val) begin
                    n_miss = n_miss + 1;
                    $display("FAIL %s port%0d: got %h, expected %h", e.name, e.port, act, e.val);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = 5'd0;

        // 1. reset holds everything at zero and discards write/alloc
        step();
        set_wr(0, 1'b1, 5'd5, 32'h0000_DEAD); alloc_en = 1'b1; alloc_addr = 5'd5;
        set_rd(5'd5, 5'd5);
        exp_rd("rst_data", 0, 32'h0); exp_rd("rst_data", 1, 32'h0); exp_busy("rst_busy", 0, 1'b0);
        step();
        rst_n = 1'b1; idle();
        exp_rd("rel_x5", 0, 32'h0); exp_busy("rel_busy", 0, 1'b0);

        // 2. write/read, x0 hardwired
        step();
        set_wr(0, 1'b1, 5'd7, 32'h1234_5678); set_rd(5'd0, 5'd0);
        exp_rd("x0_idle", 0, 32'h0);
        step();
        idle(); set_rd(5'd7, 5'd7);
        exp_rd("x7_rd", 0, 32'h1234_5678); exp_rd("x7_rd", 1, 32'h1234_5678);
        step();
        set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF); set_rd(5'd0, 5'd7);
        exp_rd("x0_nobyp", 0, 32'h0); exp_rd("x7_hold", 1, 32'h1234_5678);
        step();
        // 3. bypass on port 1 while checking x0 stayed zero
        set_wr(0, 1'b1, 5'd9, 32'hA5A5_A5A5); set_rd(5'd0, 5'd9);
        exp_rd("x0_after", 0, 32'h0); exp_rd("x9_byp", 1, 32'hA5A5_A5A5);
        step();
        idle(); set_rd(5'd9, 5'd0);
        exp_rd("x9_store", 0, 32'hA5A5_A5A5);

        // 4. collision: port 1 wins; independent dual write
        step();
        set_wr(0, 1'b1, 5'd3, 32'h11); set_wr(1, 1'b1, 5'd3, 32'h22); set_rd(5'd3, 5'd3);
        exp_rd("col_byp", 0, 32'h22);
        step();
        idle(); set_rd(5'd3, 5'd9);
        exp_rd("col_store", 0, 32'h22); exp_rd("x9_hold", 1, 32'hA5A5_A5A5);
        step();
        set_wr(0, 1'b1, 5'd10, 32'hAAAA); set_wr(1, 1'b1, 5'd11, 32'hBBBB); set_rd(5'd10, 5'd11);
        exp_rd("dual_byp0", 0, 32'hAAAA); exp_rd("dual_byp1", 1, 32'hBBBB);
        step();
        idle(); set_rd(5'd11, 5'd10);
        exp_rd("dual_st", 0, 32'hBBBB); exp_rd("dual_st", 1, 32'hAAAA);

        // 5. scoreboard
        step();
        alloc_en = 1'b1; alloc_addr = 5'd4; set_rd(5'd4, 5'd4);
        exp_busy("alloc_same", 0, 1'b0);
        step();
        idle();
        exp_busy("alloc_next", 0, 1'b1); exp_busy("alloc_next", 1, 1'b1);
        step();
        set_wr(0, 1'b1, 5'd4, 32'h44); set_rd(5'd4, 5'd5);
        exp_busy("wr_hide", 0, 1'b0); exp_rd("wr_byp4", 0, 32'h44); exp_busy("x5_free", 1, 1'b0);
        step();
        idle(); set_rd(5'd4, 5'd4);
        exp_busy("clr_after", 0, 1'b0); exp_rd("x4_st", 0, 32'h44);
        step();
        set_wr(0, 1'b1, 5'd4, 32'h55); alloc_en = 1'b1; alloc_addr = 5'd4;
        exp_busy("aw_idle", 0, 1'b0); exp_rd("aw_byp", 0, 32'h55);
        step();
        idle();
        exp_busy("set_wins", 0, 1'b1); exp_rd("x4_55", 0, 32'h55);
        step();
        set_wr(0, 1'b1, 5'd4, 32'h66); alloc_en = 1'b1; alloc_addr = 5'd4;
        exp_busy("aw_busy", 0, 1'b1); exp_rd("aw_byp66", 0, 32'h66);
        step();
        idle();
        exp_busy("still_busy", 0, 1'b1);
        step();
        set_wr(0, 1'b1, 5'd4, 32'h77);
        exp_busy("wr_hide2", 0, 1'b0);
        step();
        idle(); alloc_en = 1'b1; alloc_addr = 5'd0; set_rd(5'd0, 5'd4);
        exp_busy("x4_clear", 1, 1'b0); exp_rd("x4_77", 1, 32'h77);
        step();
        idle();
        exp_busy("x0_nobusy", 0, 1'b0);

        // 6. async reset mid-stream
        step();
        set_wr(0, 1'b1, 5'd6, 32'h99);
        step();
        idle(); alloc_en = 1'b1; alloc_addr = 5'd6;
        step();
        idle(); set_rd(5'd6, 5'd7);
        exp_rd("x6_pre", 0, 32'h99); exp_busy("x6_busy", 0, 1'b1);
        step();
        #2;
        rst_n = 1'b0; set_wr(0, 1'b1, 5'd6, 32'h123); alloc_en = 1'b1; alloc_addr = 5'd6;
        exp_rd("mid_rst", 0, 32'h0); exp_busy("mid_rst", 0, 1'b0); exp_rd("mid_rst", 1, 32'h0);
        step();
        step();
        rst_n = 1'b1; idle();
        exp_rd("post_x6", 0, 32'h0); exp_busy("post_busy", 0, 1'b0); exp_rd("post_x7", 1, 32'h0);
        step();
        set_wr(0, 1'b1, 5'd6, 32'h5A);
        step();
        idle();
        exp_rd("first_wr", 0, 32'h5A);

        step();
        step();
        if (exp_q.size() != 0) begin
            n_miss = n_miss + 1;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
